// File: rtl/sprite_overlay_pkg.sv
// Shared types and constants for the sprite overlay pixel stage:
// colour type, sprite geometry defaults, facing directions and the sprite palette.
package sprite_overlay_pkg;

    localparam int SPR_SIZE  = 32;
    localparam int ANIM_DIV  = 8;
    localparam int ANIM_FRM  = 4;
    localparam int COORD_W   = 11;
    localparam int IDX_W     = 4;
    localparam int SPR_BITS  = $clog2(SPR_SIZE);
    localparam int ANIM_BITS = $clog2(ANIM_FRM);
    // Sprite memory address: {dir, anim, row, col}
    localparam int ROM_AW    = 2 + ANIM_BITS + 2 * SPR_BITS;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Entry 0 is transparent: pixels with index 0 show the background.
    localparam rgb_t PALETTE [16] = '{
        24'h000000, 24'hF8F8F8, 24'h101010, 24'hE83820,
        24'hF0B890, 24'h2050D8, 24'h58A8F8, 24'hF8D800,
        24'hA05000, 24'h30A030, 24'h80F080, 24'hB0B0B0,
        24'h606060, 24'hD82878, 24'hF87858, 24'h402080
    };

endpackage

// File: rtl/sprite_overlay_if.sv
// Video-stream bundle between the timing generator side (master) and the
// sprite overlay stage (slave), including the sprite memory load port.
interface sprite_overlay_if;
    import sprite_overlay_pkg::*;

    logic signed [COORD_W-1:0] spot_x;
    logic signed [COORD_W-1:0] spot_y;
    logic                      blank_in;
    logic                      hs_in;
    logic                      vs_in;
    logic                      sof;
    logic                      eof;
    logic signed [COORD_W-1:0] spr_x;
    logic signed [COORD_W-1:0] spr_y;
    dir_t                      spr_dir;
    logic                      spr_moving;
    rgb_t                      bg_rgb;
    logic                      rom_we;
    logic [ROM_AW-1:0]         rom_waddr;
    logic [IDX_W-1:0]          rom_wdata;
    logic [7:0]                vga_r;
    logic [7:0]                vga_g;
    logic [7:0]                vga_b;
    logic                      vga_hs;
    logic                      vga_vs;
    logic                      vga_blank;

    modport master (
        output spot_x, spot_y, blank_in, hs_in, vs_in, sof, eof,
        output spr_x, spr_y, spr_dir, spr_moving, bg_rgb,
        output rom_we, rom_waddr, rom_wdata,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank
    );

    modport slave (
        input  spot_x, spot_y, blank_in, hs_in, vs_in, sof, eof,
        input  spr_x, spr_y, spr_dir, spr_moving, bg_rgb,
        input  rom_we, rom_waddr, rom_wdata,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank
    );

endinterface

// File: rtl/sprite_overlay_rom.sv
// Sprite pixel memory: palette indices with a one-cycle registered read and a
// host load port, mapped onto block RAM.
module sprite_overlay_rom #(
    parameter int AW = 14,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(1 << AW) - 1];
    logic [DW-1:0] r_rdata;

    // No reset: contents and read register live in the RAM primitive.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sprite_overlay.sv
// Two-stage pixel pipeline that overlays one animated sprite on the background
// colour; position/direction are frame-latched at SOF so the sprite never tears.
module sprite_overlay #(
    parameter int SPR_SIZE = sprite_overlay_pkg::SPR_SIZE,
    parameter int ANIM_DIV = sprite_overlay_pkg::ANIM_DIV,
    parameter int ANIM_FRM = sprite_overlay_pkg::ANIM_FRM
) (
    input  logic            clk,
    input  logic            rst,
    sprite_overlay_if.slave io_vid
);
    import sprite_overlay_pkg::*;

    localparam int SB = $clog2(SPR_SIZE);
    localparam int AB = $clog2(ANIM_FRM);
    localparam int AW = 2 + AB + 2 * SB;
    localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic signed [COORD_W-1:0] r_pos_x;
    logic signed [COORD_W-1:0] r_pos_y;
    dir_t                      r_dir;
    logic                      r_spr_valid;
    logic [AB-1:0]             r_anim;
    logic [CW-1:0]             r_frame_cnt;

    logic signed [COORD_W-1:0] w_pos_x;
    logic signed [COORD_W-1:0] w_pos_y;
    dir_t                      w_dir;
    logic                      w_valid;
    logic signed [COORD_W:0]   w_dx;
    logic signed [COORD_W:0]   w_dy;
    logic                      w_in_x;
    logic                      w_in_y;
    logic                      w_hit;
    logic [AW-1:0]             w_rom_addr;
    logic [IDX_W-1:0]          w_rom_idx;

    logic                      r1_hit;
    rgb_t                      r1_bg;
    logic                      r1_hs;
    logic                      r1_vs;
    logic                      r1_blank;

    logic [23:0]               w_pal;
    logic                      w_sel_spr;
    logic [23:0]               w_pix;
    logic [23:0]               r_pix;
    logic                      r_hs;
    logic                      r_vs;
    logic                      r_blank;

    // The SOF pixel itself already sees the freshly requested position.
    assign w_pos_x = io_vid.sof ? io_vid.spr_x   : r_pos_x;
    assign w_pos_y = io_vid.sof ? io_vid.spr_y   : r_pos_y;
    assign w_dir   = io_vid.sof ? io_vid.spr_dir : r_dir;
    assign w_valid = io_vid.sof | r_spr_valid;

    assign w_dx = {io_vid.spot_x[COORD_W-1], io_vid.spot_x} - {w_pos_x[COORD_W-1], w_pos_x};
    assign w_dy = {io_vid.spot_y[COORD_W-1], io_vid.spot_y} - {w_pos_y[COORD_W-1], w_pos_y};

    // 0 <= d < SPR_SIZE: sign bit and every bit above the sprite index are clear.
    assign w_in_x = (w_dx[COORD_W:SB] == '0);
    assign w_in_y = (w_dy[COORD_W:SB] == '0);
    assign w_hit  = w_valid & io_vid.blank_in & w_in_x & w_in_y;

    assign w_rom_addr = {w_dir, r_anim, w_dy[SB-1:0], w_dx[SB-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos_x     <= '0;
            r_pos_y     <= '0;
            r_dir       <= DIR_DOWN;
            r_spr_valid <= 1'b0;
            r_anim      <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (io_vid.sof) begin
                r_pos_x     <= io_vid.spr_x;
                r_pos_y     <= io_vid.spr_y;
                r_dir       <= io_vid.spr_dir;
                r_spr_valid <= 1'b1;
            end
            if (io_vid.eof) begin
                if (io_vid.spr_moving) begin
                    if (r_frame_cnt == CW'(ANIM_DIV - 1)) begin
                        r_frame_cnt <= '0;
                        r_anim      <= r_anim + AB'(1);
                    end else begin
                        r_frame_cnt <= r_frame_cnt + CW'(1);
                    end
                end else begin
                    r_frame_cnt <= '0;
                    r_anim      <= '0;
                end
            end
        end
    end

    sprite_overlay_rom #(
        .AW (AW),
        .DW (IDX_W)
    ) u_rom (
        .clk     (clk),
        .i_we    (io_vid.rom_we),
        .i_waddr (io_vid.rom_waddr),
        .i_wdata (io_vid.rom_wdata),
        .i_raddr (w_rom_addr),
        .o_rdata (w_rom_idx)
    );

    // Stage 1: side-band travels alongside the memory read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_hit   <= 1'b0;
            r1_bg    <= '0;
            r1_hs    <= 1'b0;
            r1_vs    <= 1'b0;
            r1_blank <= 1'b0;
        end else begin
            r1_hit   <= w_hit;
            r1_bg    <= io_vid.bg_rgb;
            r1_hs    <= io_vid.hs_in;
            r1_vs    <= io_vid.vs_in;
            r1_blank <= io_vid.blank_in;
        end
    end

    assign w_pal     = PALETTE[w_rom_idx];
    assign w_sel_spr = r1_hit & (w_rom_idx != '0);

    // Stage 2: per-channel colour select with blanking forced to black.
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        assign w_pix[gi*8 +: 8] = !r1_blank ? 8'd0 :
                                  w_sel_spr ? w_pal[gi*8 +: 8] : r1_bg[gi*8 +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pix   <= '0;
            r_hs    <= 1'b0;
            r_vs    <= 1'b0;
            r_blank <= 1'b0;
        end else begin
            r_pix   <= w_pix;
            r_hs    <= r1_hs;
            r_vs    <= r1_vs;
            r_blank <= r1_blank;
        end
    end

    assign io_vid.vga_r     = r_pix[23:16];
    assign io_vid.vga_g     = r_pix[15:8];
    assign io_vid.vga_b     = r_pix[7:0];
    assign io_vid.vga_hs    = r_hs;
    assign io_vid.vga_vs    = r_vs;
    assign io_vid.vga_blank = r_blank;

endmodule

// File: tb/tb_sprite_overlay.sv
// Directed-plus-random bench for sprite_overlay: a pixel-level reference model
// predicts every output word two cycles after its input.
module tb_sprite_overlay;
    import sprite_overlay_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sprite_overlay_if vif ();

    sprite_overlay dut (
        .clk    (clk),
        .rst    (rst),
        .io_vid (vif)
    );

    typedef logic [26:0] exp_t;   // {blank, hs, vs, r, g, b}

    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t exp_q[$];

    logic [3:0] m_mem [4][4][32][32];   // [dir][anim][row][col]
    int  m_px, m_py, m_dir, m_anim, m_eofs;
    bit  m_valid;

    function automatic exp_t dut_out();
        return {vif.vga_blank, vif.vga_hs, vif.vga_vs, vif.vga_r, vif.vga_g, vif.vga_b};
    endfunction

    task automatic check(input string tag, input exp_t obs, input exp_t expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic reset_model();
        m_px = 0; m_py = 0; m_dir = 0; m_anim = 0; m_eofs = 0; m_valid = 0;
        exp_q.delete();
        exp_q.push_back('0);   // stage-1 registers hold zeros after reset
    endtask

    // One pixel clock: predict the output for the current inputs, advance, compare.
    task automatic cycle();
        exp_t        e;
        int          ex, ey, ed, dx, dy;
        bit          hit;
        logic [3:0]  idx;
        logic [23:0] rgb;
        ex  = vif.sof ? int'(vif.spr_x) : m_px;
        ey  = vif.sof ? int'(vif.spr_y) : m_py;
        ed  = vif.sof ? int'(vif.spr_dir) : m_dir;
        dx  = int'(vif.spot_x) - ex;
        dy  = int'(vif.spot_y) - ey;
        hit = (m_valid || vif.sof) && vif.blank_in &&
              dx >= 0 && dx < 32 && dy >= 0 && dy < 32;
        idx = hit ? m_mem[ed][m_anim][dy][dx] : 4'd0;
        rgb = (idx != 0) ? PALETTE[idx] : vif.bg_rgb;
        if (!vif.blank_in) rgb = '0;
        exp_q.push_back({vif.blank_in, vif.hs_in, vif.vs_in, rgb});
        if (vif.sof) begin
            m_px = ex; m_py = ey; m_dir = ed; m_valid = 1;
        end
        if (vif.eof) begin
            if (vif.spr_moving) begin
                m_eofs++;
                if (m_eofs == 8) begin
                    m_eofs = 0;
                    m_anim = (m_anim + 1) % 4;
                end
            end else begin
                m_eofs = 0;
                m_anim = 0;
            end
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("pixel", dut_out(), e);
    endtask

    task automatic drive_misc();
        vif.hs_in  = 1'($urandom);
        vif.vs_in  = 1'($urandom);
        vif.bg_rgb = rgb_t'($urandom);
    endtask

    task automatic drive_blank();
        vif.spot_x = -11'sd1; vif.spot_y = -11'sd1;
        vif.blank_in = 1'b0; vif.sof = 1'b0; vif.eof = 1'b0;
        drive_misc();
    endtask

    task automatic drive_active(input int x, input int y, input bit s, input bit e, input bit force_on);
        vif.spot_x   = 11'(x);
        vif.spot_y   = 11'(y);
        vif.blank_in = force_on ? 1'b1 : ($urandom_range(0, 11) != 0);
        vif.sof      = s;
        vif.eof      = e;
        drive_misc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_blank();
            cycle();
        end
    endtask

    // One frame over the given window; spr_x may be changed at row chg_row.
    task automatic frame(input int x0, input int x1, input int y0, input int y1,
                         input int chg_row, input int chg_x);
        for (int y = y0; y <= y1; y++) begin
            if (y == chg_row) vif.spr_x = 11'(chg_x);
            for (int x = x0; x <= x1; x++) begin
                drive_active(x, y, (x == x0 && y == y0), (x == x1 && y == y1),
                             (x == x0 && y == y0) || (x == x1 && y == y1));
                cycle();
            end
            idle(3);
        end
    endtask

    task automatic load_rom(input bit ones_block);
        int nd, na;
        nd = ones_block ? 1 : 4;
        na = ones_block ? 1 : 4;
        for (int d = 0; d < nd; d++)
            for (int a = 0; a < na; a++)
                for (int r = 0; r < 32; r++)
                    for (int c = 0; c < 32; c++) begin
                        m_mem[d][a][r][c] = ones_block ? 4'd1 : 4'($urandom);
                        drive_blank();
                        vif.rom_we    = 1'b1;
                        vif.rom_waddr = {2'(d), 2'(a), 5'(r), 5'(c)};
                        vif.rom_wdata = m_mem[d][a][r][c];
                        cycle();
                    end
        vif.rom_we = 1'b0;
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1 check("async_reset", dut_out(), '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        reset_model();
    endtask

    initial begin
        vif.spot_x = '0; vif.spot_y = '0; vif.blank_in = 1'b0;
        vif.hs_in = 1'b0; vif.vs_in = 1'b0; vif.sof = 1'b0; vif.eof = 1'b0;
        vif.spr_x = '0; vif.spr_y = '0; vif.spr_dir = DIR_DOWN; vif.spr_moving = 1'b0;
        vif.bg_rgb = '0; vif.rom_we = 1'b0; vif.rom_waddr = '0; vif.rom_wdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 check("reset_state", dut_out(), '0);
        rst = 1'b0;
        reset_model();
        idle(4);

        load_rom(1'b0);

        // Sprite at (100,50) with an all-index-1 image
        load_rom(1'b1);
        vif.spr_x = 11'sd100; vif.spr_y = 11'sd50; vif.spr_dir = DIR_DOWN;
        frame(96, 135, 48, 84, -1, 0);

        // Reset in the middle of a line; nothing drawn until the next SOF
        for (int x = 96; x < 136; x++) begin
            drive_active(x, 55, x == 96, 1'b0, 1'b0);
            cycle();
            if (x == 115) mid_reset();
        end
        idle(3);
        for (int x = 96; x < 136; x++) begin
            drive_active(x, 60, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        idle(3);
        frame(96, 135, 55, 62, -1, 0);

        // Clipping at the left and bottom edges, no wrap-around
        vif.spr_x = -11'sd10; vif.spr_y = 11'sd590; vif.spr_dir = DIR_LEFT;
        frame(0, 25, 585, 599, -1, 0);
        frame(780, 799, 585, 599, -1, 0);
        frame(0, 25, 0, 4, -1, 0);

        // Position change mid-frame only takes effect at the next SOF
        vif.spr_x = 11'sd100; vif.spr_y = 11'sd50; vif.spr_dir = DIR_RIGHT;
        frame(96, 235, 48, 57, 53, 200);
        frame(96, 235, 48, 57, -1, 0);

        // Walk animation across 41 EOFs, including 1-pixel frames (SOF==EOF)
        vif.spr_x = 11'sd100; vif.spr_y = 11'sd50; vif.spr_dir = DIR_UP;
        vif.spr_moving = 1'b1;
        for (int i = 0; i < 41; i++) begin
            if (i % 3 == 0) frame(110, 110, 60, 60, -1, 0);
            else            frame(108, 111, 60, 61, -1, 0);
        end
        vif.spr_moving = 1'b0;
        frame(108, 111, 60, 61, -1, 0);
        frame(108, 111, 60, 61, -1, 0);

        // Randomized placement, direction and motion
        for (int i = 0; i < 4; i++) begin
            vif.spr_x      = 11'($urandom_range(80, 140));
            vif.spr_y      = 11'($urandom_range(40, 70));
            vif.spr_dir    = dir_t'($urandom_range(0, 3));
            vif.spr_moving = 1'($urandom);
            frame(90, 150, 45, 80, -1, 0);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
